// File: rtl/pea_pkg.sv
// pea_pkg: shared opcodes, status codes, FSM states and log2 helper for the PEA execution stage
package pea_pkg;
    localparam logic [7:0] OP_STP = 8'd1;
    localparam logic [7:0] OP_EVP = 8'd2;
    localparam logic [7:0] OP_EVB = 8'd3;
    localparam logic [7:0] OP_CLR = 8'd4;

    localparam int ST_OK       = 0;
    localparam int ST_BAD_OP   = 1;
    localparam int ST_BAD_DEG  = 2;
    localparam int ST_NO_POLY  = 3;
    localparam int ST_ZERO_CNT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_LOAD,
        S_READ_X,
        S_HORNER,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic int pea_log2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pea_horner_mac.sv
// pea_horner_mac: combinational y = acc*x + c, operands zero-extended, result modulo 2^OUT_WIDTH
//   acc : running accumulator
//   x   : evaluation point
//   c   : current coefficient
//   y   : next accumulator value
module pea_horner_mac #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic [OUT_WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     c,
    output logic [OUT_WIDTH-1:0] y
);
    logic [OUT_WIDTH-1:0] xe, ce;
    assign xe = {{(OUT_WIDTH-WIDTH){1'b0}}, x};
    assign ce = {{(OUT_WIDTH-WIDTH){1'b0}}, c};
    assign y  = acc * xe + ce;
endmodule

// File: rtl/pea_poly_exec.sv
// pea_poly_exec: PEA execution stage; stores coefficients and evaluates the polynomial by Horner's rule
//   start/instr/arg2 : command from the get-command FSM
//   data_in/data_count/rd_data : data FIFO head, population and pop strobe
//   wr_out/result/status : one push per response into the output FIFOs
//   busy/done : command in progress / one-cycle completion pulse
module pea_poly_exec
    import pea_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32,
    parameter int MAX_DEG   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                instr,
    input  logic [4:0]                arg2,
    input  logic [WIDTH-1:0]          data_in,
    input  logic [pea_log2(1024)-1:0] data_count,
    output logic                      rd_data,
    output logic                      wr_out,
    output logic [OUT_WIDTH-1:0]      result,
    output logic [OUT_WIDTH-1:0]      status,
    output logic                      busy,
    output logic                      done
);
    localparam int         IW    = pea_log2(MAX_DEG + 1);
    localparam logic [4:0] MAX_N = 5'(MAX_DEG);

    state_t               state;
    logic [7:0]           op;
    logic [4:0]           arg;
    logic [4:0]           rem;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        degree;
    logic                 coef_valid;
    logic [WIDTH-1:0]     x;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] mac_y;
    logic [WIDTH-1:0]     coef [0:MAX_DEG];

    // Pops are combinational so a word is taken in the same cycle it becomes available.
    assign rd_data = (state == S_LOAD || state == S_READ_X) && data_count != '0;

    pea_horner_mac #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_mac (
        .acc(acc),
        .x  (x),
        .c  (coef[idx]),
        .y  (mac_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op         <= '0;
            arg        <= '0;
            rem        <= '0;
            idx        <= '0;
            degree     <= '0;
            coef_valid <= 1'b0;
            x          <= '0;
            acc        <= '0;
            wr_out     <= 1'b0;
            result     <= '0;
            status     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i <= MAX_DEG; i++) coef[i] <= '0;
        end else begin
            wr_out <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op    <= instr;
                    arg   <= arg2;
                    busy  <= 1'b1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    result <= '0;
                    rem    <= '0;
                    if (op == OP_STP && arg <= MAX_N) begin
                        idx   <= arg[IW-1:0];
                        state <= S_LOAD;
                    end else if ((op == OP_EVP || op == OP_EVB) && coef_valid && !(op == OP_EVB && arg == '0)) begin
                        rem   <= op == OP_EVB ? arg : 5'd1;
                        state <= S_READ_X;
                    end else begin
                        // Error and CLR paths answer immediately without touching the data FIFO.
                        wr_out <= 1'b1;
                        state  <= S_WRITE;
                        status <= OUT_WIDTH'(op == OP_STP ? ST_BAD_DEG :
                                  (op == OP_EVP || op == OP_EVB) ? (coef_valid ? ST_ZERO_CNT : ST_NO_POLY) :
                                  op == OP_CLR ? ST_OK : ST_BAD_OP);
                        if (op == OP_CLR) coef_valid <= 1'b0;
                    end
                end
                S_LOAD: if (rd_data) begin
                    // Coefficients arrive highest degree first.
                    coef[idx] <= data_in;
                    if (idx == '0) begin
                        degree     <= arg[IW-1:0];
                        coef_valid <= 1'b1;
                        wr_out     <= 1'b1;
                        result     <= '0;
                        status     <= OUT_WIDTH'(ST_OK);
                        state      <= S_WRITE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_READ_X: if (rd_data) begin
                    x     <= data_in;
                    acc   <= '0;
                    idx   <= degree;
                    state <= S_HORNER;
                end
                S_HORNER: begin
                    acc <= mac_y;
                    if (idx == '0) begin
                        wr_out <= 1'b1;
                        result <= mac_y;
                        status <= OUT_WIDTH'(ST_OK);
                        state  <= S_WRITE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_WRITE: if (rem > 5'd1) begin
                    rem   <= rem - 5'd1;
                    state <= S_READ_X;
                end else begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
